// File: rtl/adxl362_spi_master_pkg.sv
// Shared definitions for the ADXL362 SPI master.
//  - ADXL362 instruction bytes and frequently used register addresses
//  - FSM state encoding
//  - next_tx_byte(): selects the byte shifted out at a given frame position
package adxl362_spi_master_pkg;

    localparam logic [7:0] ADXL_INSTR_WRITE = 8'h0A;
    localparam logic [7:0] ADXL_INSTR_READ  = 8'h0B;
    localparam logic [7:0] ADXL_INSTR_FIFO  = 8'h0D;

    localparam logic [7:0] DEVID_AD  = 8'h00;
    localparam logic [7:0] DEVID_MST = 8'h01;
    localparam logic [7:0] PARTID    = 8'h02;
    localparam logic [7:0] POWER_CTL = 8'h2D;
    localparam logic [7:0] XDATA_L   = 8'h0E;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Byte index 0 (instruction) is loaded at accept time, so only indices
    // 1 and up are produced here. Everything past the address on a read is a
    // dummy 0x00 that clocks the device's reply out.
    function automatic logic [7:0] next_tx_byte(input logic [3:0] idx,
                                                input logic       is_write,
                                                input logic [7:0] addr,
                                                input logic [7:0] wr_data);
        logic [7:0] b;
        case (idx)
            4'd1:    b = addr;
            4'd2:    b = is_write ? wr_data : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adxl362_spi_master_spi_clk_gen.sv
// SCK edge-enable generator.
//  clk_in    in  system clock
//  reset_in  in  asynchronous active-low reset
//  en        in  high while the master is in XFER; low clears the divider
//  sck_rise  out one-cycle enable: SCK should rise on this clock edge
//  sck_fall  out one-cycle enable: SCK should fall on this clock edge
// The first enable after en rises is a rise, CLK_DIV cycles later.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic en,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_r;
    logic          phase_r;
    logic          tick_s;

    assign tick_s   = en && (div_r == CW'(CLK_DIV - 1));
    assign sck_rise = tick_s && !phase_r;
    assign sck_fall = tick_s && phase_r;

    // Half-period divider; phase_r tracks whether the next tick is a fall.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (!en) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (tick_s) begin
            div_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            div_r   <= div_r + CW'(1);
        end
    end

endmodule

// File: rtl/adxl362_spi_master.sv
// SPI master (mode 0, MSB first) for the ADXL362 accelerometer.
// Frame: instruction, address, then one write byte or 1..8 read bytes.
//  clk_in/reset_in          system clock, asynchronous active-low reset
//  start                    command strobe, accepted only while busy==0
//  cmd_write/addr/wr_data   command fields, latched on accept
//  burst_len                read byte count minus one
//  busy/done                frame in progress / one-cycle end-of-frame pulse
//  rd_data/rd_valid         received byte and its one-cycle strobe
//  sck_o/ncs_o/mosi_o/miso_i  SPI pins
module adxl362_spi_master
    import adxl362_spi_master_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start,
    input  logic       cmd_write,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] burst_len,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       sck_o,
    output logic       ncs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    state_t      state_r, state_nx_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_limit_s;
    logic        cnt_done_s;
    logic [2:0]  bit_cnt_r;
    logic [3:0]  byte_cnt_r;
    logic [3:0]  last_idx_s;
    logic        cmd_write_r;
    logic [7:0]  addr_r;
    logic [7:0]  wr_data_r;
    logic [2:0]  burst_len_r;
    logic [7:0]  tx_r;
    logic [7:0]  rx_r;
    logic [7:0]  instr_s;
    logic [7:0]  next_byte_s;
    logic        miso_meta_r;
    logic        miso_sync_r;
    logic        sck_rise_s;
    logic        sck_fall_s;
    logic        accept_s;
    logic        frame_end_s;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .en       (state_r == ST_XFER),
        .sck_rise (sck_rise_s),
        .sck_fall (sck_fall_s)
    );

    assign instr_s     = cmd_write ? ADXL_INSTR_WRITE : ADXL_INSTR_READ;
    assign accept_s    = (state_r == ST_IDLE) && start && !busy;
    assign last_idx_s  = cmd_write_r ? 4'd2 : (4'd2 + {1'b0, burst_len_r});
    assign frame_end_s = sck_fall_s && (bit_cnt_r == 3'd0) && (byte_cnt_r == last_idx_s);
    assign next_byte_s = next_tx_byte(byte_cnt_r + 4'd1, cmd_write_r, addr_r, wr_data_r);
    assign cnt_done_s  = (cnt_r == cnt_limit_s);

    // Terminal count for the timed states (cycles spent in the state minus one).
    always_comb begin
        cnt_limit_s = 8'd0;
        case (state_r)
            ST_SETUP: cnt_limit_s = 8'(CS_SETUP - 1);
            ST_HOLD:  cnt_limit_s = 8'(CS_HOLD - 1);
            ST_GAP:   cnt_limit_s = 8'(CS_IDLE - 1);
            default:  cnt_limit_s = 8'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s)    state_nx_s = ST_SETUP; else state_nx_s = ST_IDLE;
            ST_SETUP: if (cnt_done_s)  state_nx_s = ST_XFER;  else state_nx_s = ST_SETUP;
            ST_XFER:  if (frame_end_s) state_nx_s = ST_HOLD;  else state_nx_s = ST_XFER;
            ST_HOLD:  if (cnt_done_s)  state_nx_s = ST_GAP;   else state_nx_s = ST_HOLD;
            ST_GAP:   if (cnt_done_s)  state_nx_s = ST_IDLE;  else state_nx_s = ST_GAP;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_r <= ST_IDLE;
        else           state_r <= state_nx_s;
    end

    // Two-flop synchroniser for the asynchronous MISO pin.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= miso_i;
            miso_sync_r <= miso_meta_r;
        end
    end

    // Datapath: command latch, shift registers, counters and pin registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
            sck_o       <= 1'b0;
            ncs_o       <= 1'b1;
            mosi_o      <= 1'b0;
            cnt_r       <= 8'd0;
            bit_cnt_r   <= 3'd7;
            byte_cnt_r  <= 4'd0;
            cmd_write_r <= 1'b0;
            addr_r      <= 8'h00;
            wr_data_r   <= 8'h00;
            burst_len_r <= 3'd0;
            tx_r        <= 8'h00;
            rx_r        <= 8'h00;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 8'd0;
                    if (accept_s) begin
                        cmd_write_r <= cmd_write;
                        addr_r      <= addr;
                        wr_data_r   <= wr_data;
                        burst_len_r <= burst_len;
                        busy        <= 1'b1;
                        ncs_o       <= 1'b0;
                        mosi_o      <= instr_s[7];
                        tx_r        <= {instr_s[6:0], 1'b0};
                        bit_cnt_r   <= 3'd7;
                        byte_cnt_r  <= 4'd0;
                    end
                end
                ST_SETUP: begin
                    cnt_r <= cnt_done_s ? 8'd0 : cnt_r + 8'd1;
                end
                ST_XFER: begin
                    if (sck_rise_s) begin
                        sck_o <= 1'b1;
                        rx_r  <= {rx_r[6:0], miso_sync_r};
                    end else if (sck_fall_s) begin
                        sck_o <= 1'b0;
                        if (bit_cnt_r == 3'd0) begin
                            // Bytes past the address on a read carry device data.
                            if (!cmd_write_r && (byte_cnt_r >= 4'd2)) begin
                                rd_data  <= rx_r;
                                rd_valid <= 1'b1;
                            end
                            if (byte_cnt_r == last_idx_s) begin
                                mosi_o <= 1'b0;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 4'd1;
                                bit_cnt_r  <= 3'd7;
                                mosi_o     <= next_byte_s[7];
                                tx_r       <= {next_byte_s[6:0], 1'b0};
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            mosi_o    <= tx_r[7];
                            tx_r      <= {tx_r[6:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_done_s) begin
                        cnt_r <= 8'd0;
                        ncs_o <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_done_s) begin
                        cnt_r <= 8'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    sck_o <= 1'b0;
                    ncs_o <= 1'b1;
                    busy  <= 1'b0;
                    cnt_r <= 8'd0;
                end
            endcase
        end
    end

endmodule
